// File: rtl/matrix_stream_loader_pkg.sv
// Shared definitions for the systolic multiplier front end: loader FSM encoding,
// default matrix geometry and the element-counter width helper.
package systolic_pkg;

   localparam int DEF_DATA_WIDTH = 8;
   localparam int DEF_M          = 8;
   localparam int DEF_N          = 8;
   localparam int DEF_P          = 8;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD_A,
      ST_LOAD_B,
      ST_START,
      ST_WAIT_DONE
   } loader_state_t;

   // A single-element matrix still needs a one-bit counter.
   function automatic int cnt_width(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/matrix_stream_loader_if.sv
// Element stream carrying A then B into the matrix loader (valid/ready with frame marker).
import systolic_pkg::*;

interface matrix_stream_loader_if #(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH
);
   logic                  s_valid;
   logic                  s_ready;
   logic [DATA_WIDTH-1:0] s_data;
   logic                  s_last;

   modport master (output s_valid, output s_data, output s_last, input s_ready);
   modport slave  (input s_valid, input s_data, input s_last, output s_ready);
endinterface

// File: rtl/matrix_stream_loader_pack_reg.sv
// Packed matrix register with indexed single-element write; clears on async reset.
import systolic_pkg::*;

module matrix_pack_reg #(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int DEPTH      = 4,
   parameter int IDX_W      = 2
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        we,
   input  logic [IDX_W-1:0]            idx,
   input  logic [DATA_WIDTH-1:0]       wdata,
   output logic [DEPTH*DATA_WIDTH-1:0] data
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         data <= '0;
      end else if (we) begin
         data[int'(idx)*DATA_WIDTH +: DATA_WIDTH] <= wdata;
      end
   end

endmodule

// File: rtl/matrix_stream_loader.sv
// Collects a row-major A then B element stream into packed matrices and pulses the multiplier.
// Optional s_last framing check enabled by defining LOADER_LAST_CHECK_EN.
import systolic_pkg::*;

module matrix_stream_loader #(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int M          = DEF_M,
   parameter int N          = DEF_N,
   parameter int P          = DEF_P
) (
   input  logic                         clk,
   input  logic                         rst,
   matrix_stream_loader_if.slave        s_if,
   output logic                         mm_start,
   input  logic                         mm_done,
   output logic [M*N*DATA_WIDTH-1:0]    matrix_a,
   output logic [N*P*DATA_WIDTH-1:0]    matrix_b,
   output logic                         busy,
   output logic                         err_frame
);

   localparam int A_SIZE = M * N;
   localparam int B_SIZE = N * P;
   localparam int CNT_W  = cnt_width((A_SIZE > B_SIZE) ? A_SIZE : B_SIZE);
   localparam logic [CNT_W-1:0] A_LAST = CNT_W'(A_SIZE - 1);
   localparam logic [CNT_W-1:0] B_LAST = CNT_W'(B_SIZE - 1);

   loader_state_t    state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             mm_done_p1;
   logic             ready;
   logic             xfer;
   logic             frame_bad;
   logic             we_a, we_b;

   assign ready       = (state_q == ST_LOAD_A) || (state_q == ST_LOAD_B);
   assign s_if.s_ready = ready;
   assign busy        = (state_q == ST_START) || (state_q == ST_WAIT_DONE);
   assign xfer        = s_if.s_valid && ready;
   assign we_a        = xfer && (state_q == ST_LOAD_A);
   assign we_b        = xfer && (state_q == ST_LOAD_B);

`ifdef LOADER_LAST_CHECK_EN
   logic err_q;

   // s_last must be high on exactly the final B element and nowhere else.
   assign frame_bad = xfer &&
                      (s_if.s_last != ((state_q == ST_LOAD_B) && (cnt_q == B_LAST)));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_q <= 1'b0;
      end else if (frame_bad) begin
         err_q <= 1'b1;
      end
   end

   assign err_frame = err_q;
`else
   logic unused_last;

   assign unused_last = s_if.s_last;
   assign frame_bad   = 1'b0;
   assign err_frame   = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_IDLE: state_d = ST_LOAD_A;
         ST_LOAD_A: begin
            if (xfer) begin
               if (frame_bad) begin
                  cnt_d = '0;
               end else if (cnt_q == A_LAST) begin
                  cnt_d   = '0;
                  state_d = ST_LOAD_B;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         ST_LOAD_B: begin
            if (xfer) begin
               if (frame_bad) begin
                  cnt_d   = '0;
                  state_d = ST_LOAD_A;
               end else if (cnt_q == B_LAST) begin
                  cnt_d   = '0;
                  state_d = ST_START;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         ST_START: state_d = ST_WAIT_DONE;
         // Only a fresh rising edge counts; a level left high by the last job is ignored.
         ST_WAIT_DONE: begin
            if (mm_done && !mm_done_p1) begin
               state_d = ST_LOAD_A;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         mm_start   <= 1'b0;
         mm_done_p1 <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         mm_start   <= (state_d == ST_START);
         mm_done_p1 <= mm_done;
      end
   end

   matrix_pack_reg #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (A_SIZE),
      .IDX_W      (CNT_W)
   ) u_pack_a (
      .clk   (clk),
      .rst   (rst),
      .we    (we_a),
      .idx   (cnt_q),
      .wdata (s_if.s_data),
      .data  (matrix_a)
   );

   matrix_pack_reg #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (B_SIZE),
      .IDX_W      (CNT_W)
   ) u_pack_b (
      .clk   (clk),
      .rst   (rst),
      .we    (we_b),
      .idx   (cnt_q),
      .wdata (s_if.s_data),
      .data  (matrix_b)
   );

endmodule

// File: tb/tb_matrix_stream_loader.sv
// Bench for matrix_stream_loader at M=N=P=2, DATA_WIDTH=8: vector table, hand sequences, random frames.
`timescale 1ns/1ps
module tb_matrix_stream_loader;

   localparam int DW = 8;
   localparam int MM = 2;
   localparam int NN = 2;
   localparam int PP = 2;
   localparam int AW = MM * NN * DW;
   localparam int BW = NN * PP * DW;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          mm_start;
   logic          mm_done = 1'b0;
   logic          busy;
   logic          err_frame;
   logic [AW-1:0] matrix_a;
   logic [BW-1:0] matrix_b;

   matrix_stream_loader_if #(.DATA_WIDTH(DW)) sif ();

   matrix_stream_loader #(
      .DATA_WIDTH (DW),
      .M          (MM),
      .N          (NN),
      .P          (PP)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .s_if      (sif),
      .mm_start  (mm_start),
      .mm_done   (mm_done),
      .matrix_a  (matrix_a),
      .matrix_b  (matrix_b),
      .busy      (busy),
      .err_frame (err_frame)
   );

   always #5 clk = ~clk;

   int checks  = 0;
   int errors  = 0;
   int n_start = 0;

   always @(negedge clk) if (mm_start === 1'b1) n_start++;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1, "watchdog");
   end

   typedef struct packed {
      logic [63:0] elems;   // a0..a3 then b0..b3, element 0 in the low byte
      logic [3:0]  gap;
      logic [31:0] exp_a;
      logic [31:0] exp_b;
   } vec_t;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
      end
   endtask

   // Starts and ends #1 after a rising edge.
   task automatic xfer(input logic [7:0] d, input logic last, input int gap);
      bit ok;
      ok = 1'b0;
      repeat (gap) begin @(posedge clk); #1; end
      sif.s_valid = 1'b1;
      sif.s_data  = d;
      sif.s_last  = last;
      for (int t = 0; t < 64 && !ok; t++) begin
         @(negedge clk);
         ok = (sif.s_ready === 1'b1);
         @(posedge clk); #1;
      end
      sif.s_valid = 1'b0;
      sif.s_last  = 1'b0;
      chk("xfer_accept", {63'd0, ok}, 64'd1);
   endtask

   task automatic send_frame(input logic [63:0] elems, input int gap, input logic [7:0] last_mask);
      for (int i = 0; i < 8; i++) begin
         xfer(elems[i*8 +: 8], last_mask[i], (gap < 0) ? int'($urandom_range(0, 2)) : gap);
      end
   endtask

   // Model: element i of a matrix lands at weight 256**i.
   function automatic logic [31:0] pack_model(input logic [7:0] e0, e1, e2, e3);
      logic [31:0] v;
      v = 32'd0;
      v = v + 32'(e0);
      v = v + (32'(e1) * 32'd256);
      v = v + (32'(e2) * 32'd65536);
      v = v + (32'(e3) * 32'd16777216);
      return v;
   endfunction

   // Called #1 after the final B transfer edge.
   task automatic check_operation(input logic [31:0] ea, input logic [31:0] eb,
                                  input int hold, input int s0);
      @(negedge clk);
      chk("start_pulse", {63'd0, mm_start}, 64'd1);
      chk("busy_start", {63'd0, busy}, 64'd1);
      chk("ready_start", {63'd0, sif.s_ready}, 64'd0);
      chk("matrix_a", {32'd0, matrix_a}, {32'd0, ea});
      chk("matrix_b", {32'd0, matrix_b}, {32'd0, eb});
      for (int c = 0; c < hold + 1; c++) begin
         @(negedge clk);
         chk("start_low_wait", {63'd0, mm_start}, 64'd0);
         chk("busy_wait", {63'd0, busy}, 64'd1);
         chk("ready_wait", {63'd0, sif.s_ready}, 64'd0);
         chk("a_stable", {32'd0, matrix_a}, {32'd0, ea});
         chk("b_stable", {32'd0, matrix_b}, {32'd0, eb});
      end
      @(posedge clk); #1 mm_done = 1'b1;
      @(posedge clk); #1 mm_done = 1'b0;
      @(negedge clk);
      chk("ready_after_done", {63'd0, sif.s_ready}, 64'd1);
      chk("busy_after_done", {63'd0, busy}, 64'd0);
      chk("start_count", 64'(n_start - s0), 64'd1);
      @(posedge clk); #1;
   endtask

   vec_t vecs [4];

   initial begin
      int s0;
      logic [7:0] r [8];
      logic [63:0] re;

      vecs[0] = '{elems: 64'h0807060504030201, gap: 4'd0, exp_a: 32'h04030201, exp_b: 32'h08070605};
      vecs[1] = '{elems: 64'h0807060504030201, gap: 4'd1, exp_a: 32'h04030201, exp_b: 32'h08070605};
      vecs[2] = '{elems: 64'hF87F01FF80007FF8, gap: 4'd0, exp_a: 32'h80007FF8, exp_b: 32'hF87F01FF};
      vecs[3] = '{elems: 64'h78563412FF0055AA, gap: 4'd2, exp_a: 32'hFF0055AA, exp_b: 32'h78563412};

      sif.s_valid = 1'b0;
      sif.s_data  = '0;
      sif.s_last  = 1'b0;

      // Reset state
      @(negedge clk);
      chk("rst_a", {32'd0, matrix_a}, 64'd0);
      chk("rst_b", {32'd0, matrix_b}, 64'd0);
      chk("rst_start", {63'd0, mm_start}, 64'd0);
      chk("rst_busy", {63'd0, busy}, 64'd0);
      chk("rst_ready", {63'd0, sif.s_ready}, 64'd0);
      chk("rst_err", {63'd0, err_frame}, 64'd0);
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      chk("idle_ready", {63'd0, sif.s_ready}, 64'd0);
      @(posedge clk); #1;
      @(negedge clk);
      chk("load_a_ready", {63'd0, sif.s_ready}, 64'd1);
      @(posedge clk); #1;

      // Vector table
      for (int v = 0; v < 4; v++) begin
         s0 = n_start;
         send_frame(vecs[v].elems, int'(vecs[v].gap), 8'h80);
         check_operation(vecs[v].exp_a, vecs[v].exp_b, 2, s0);
      end

      // mm_done already high when the second job starts
      s0 = n_start;
      send_frame(vecs[0].elems, 0, 8'h80);
      @(negedge clk);
      chk("d1_start", {63'd0, mm_start}, 64'd1);
      @(posedge clk); #1 mm_done = 1'b1;
      @(posedge clk); #1;
      send_frame(vecs[3].elems, 0, 8'h80);
      @(negedge clk);
      chk("d2_start", {63'd0, mm_start}, 64'd1);
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         chk("held_level_busy", {63'd0, busy}, 64'd1);
      end
      @(posedge clk); #1 mm_done = 1'b0;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         chk("low_busy", {63'd0, busy}, 64'd1);
         chk("low_ready", {63'd0, sif.s_ready}, 64'd0);
      end
      @(posedge clk); #1 mm_done = 1'b1;
      @(negedge clk);
      chk("edge_pending_busy", {63'd0, busy}, 64'd1);
      @(negedge clk);
      chk("edge_exit_ready", {63'd0, sif.s_ready}, 64'd1);
      chk("edge_exit_busy", {63'd0, busy}, 64'd0);
      chk("d_start_count", 64'(n_start - s0), 64'd2);
      chk("d2_matrix_a", {32'd0, matrix_a}, 64'hFF0055AA);
      @(posedge clk); #1 mm_done = 1'b0;

      // Reset in the middle of loading A
      s0 = n_start;
      xfer(8'h11, 1'b0, 0);
      xfer(8'h22, 1'b0, 0);
      xfer(8'h33, 1'b0, 0);
      rst = 1'b1;
      #1;
      chk("mid_rst_a", {32'd0, matrix_a}, 64'd0);
      chk("mid_rst_b", {32'd0, matrix_b}, 64'd0);
      chk("mid_rst_start", {63'd0, mm_start}, 64'd0);
      chk("mid_rst_busy", {63'd0, busy}, 64'd0);
      chk("mid_rst_ready", {63'd0, sif.s_ready}, 64'd0);
      chk("mid_rst_err", {63'd0, err_frame}, 64'd0);
      @(posedge clk); #1 rst = 1'b0;
      send_frame(vecs[2].elems, 0, 8'h80);
      check_operation(vecs[2].exp_a, vecs[2].exp_b, 1, s0);

      // Random frames against the packing model
      for (int f = 0; f < 12; f++) begin
         for (int i = 0; i < 8; i++) r[i] = 8'($urandom);
         re = {r[7], r[6], r[5], r[4], r[3], r[2], r[1], r[0]};
         s0 = n_start;
         send_frame(re, -1, 8'h80);
         check_operation(pack_model(r[0], r[1], r[2], r[3]),
                         pack_model(r[4], r[5], r[6], r[7]),
                         int'($urandom_range(0, 3)), s0);
      end

`ifdef LOADER_LAST_CHECK_EN
      // s_last on A[2]: error, restart at A[0], no start pulse for the broken frame
      chk("err_before", {63'd0, err_frame}, 64'd0);
      s0 = n_start;
      xfer(8'h91, 1'b0, 0);
      xfer(8'h92, 1'b0, 0);
      xfer(8'h93, 1'b1, 0);
      @(negedge clk);
      chk("err_set", {63'd0, err_frame}, 64'd1);
      chk("err_ready", {63'd0, sif.s_ready}, 64'd1);
      chk("err_busy", {63'd0, busy}, 64'd0);
      @(posedge clk); #1;
      send_frame(vecs[0].elems, 0, 8'h80);
      check_operation(vecs[0].exp_a, vecs[0].exp_b, 0, s0);
      chk("err_sticky", {63'd0, err_frame}, 64'd1);
`else
      // s_last carries no meaning in this build
      s0 = n_start;
      send_frame(vecs[3].elems, 0, 8'h5A);
      check_operation(vecs[3].exp_a, vecs[3].exp_b, 0, s0);
      chk("err_tied_low", {63'd0, err_frame}, 64'd0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/matrix_stream_loader.md
MATRIX_STREAM_LOADER -- requirements
Module: matrix_stream_loader

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, meaning element width in bits (two's complement).
REQ-002 SHALL have parameters M, N, P, default 8 each; A is MxN, B is NxP, matching the downstream systolic_matrix_multiplier.
REQ-003 clk  input  1  sole clock; all logic on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 s_valid  input  1  upstream element valid.
REQ-006 s_ready  output  1  loader accepts element this cycle.
REQ-007 s_data  input  DATA_WIDTH  element value.
REQ-008 s_last  input  1  upstream marks final element of a frame (A then B).
REQ-009 mm_start  output  1  one-cycle start pulse to the multiplier.
REQ-010 mm_done  input  1  multiplier done level.
REQ-011 matrix_a  output  M*N*DATA_WIDTH  packed A; element i (row-major, i=r*N+c) at bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-012 matrix_b  output  N*P*DATA_WIDTH  packed B; element k*P+j, same packing.
REQ-013 busy  output  1  high in START and WAIT_DONE.
REQ-014 err_frame  output  1  sticky framing error flag.

Function
REQ-015 FSM states SHALL be IDLE, LOAD_A, LOAD_B, START, WAIT_DONE.
REQ-016 IDLE SHALL transition unconditionally to LOAD_A on the next clock.
REQ-017 s_ready SHALL be 1 exactly in LOAD_A and LOAD_B; a transfer is s_valid && s_ready on a rising edge.
REQ-018 Stream order SHALL be all M*N A elements, then all N*P B elements, both row-major; each transfer writes the indexed element and increments the element counter.
REQ-019 Transfer of A element M*N-1 SHALL clear the counter and enter LOAD_B; B element N*P-1 SHALL clear the counter and enter START.
REQ-020 Counter SHALL never exceed the matrix size; no wrap into the other matrix.
REQ-021 mm_start SHALL be registered, high for exactly the one cycle spent in START, i.e. the cycle after the final B transfer; START always moves to WAIT_DONE.
REQ-022 WAIT_DONE SHALL exit to LOAD_A on a rising edge of mm_done (mm_done high, previous-cycle sample low); a level held high from a previous operation SHALL NOT end the wait.
REQ-023 matrix_a and matrix_b SHALL hold stable from START until WAIT_DONE exits; they are overwritten only element by element during the next load.
REQ-024 s_valid low SHALL stall loading indefinitely with no state change (bubbles allowed anywhere).
REQ-025 s_data is not interpreted arithmetically; stored bit-exact.

Reset
REQ-026 rst SHALL asynchronously force state IDLE, counter 0, matrix_a=0, matrix_b=0, mm_start=0, err_frame=0, mm_done history=0; s_ready=0, busy=0.
REQ-027 rst mid-load or mid-wait SHALL discard the partial frame; no mm_start is issued for it.

Configuration
REQ-028 With LOADER_LAST_CHECK_EN defined: s_last high on any transfer other than B element N*P-1, or low on that element, SHALL set err_frame, clear the counter, return to LOAD_A and issue no mm_start; err_frame clears only on rst.
REQ-029 Without LOADER_LAST_CHECK_EN: s_last SHALL be ignored and err_frame tied 0.

Structure
REQ-030 Shared package systolic_pkg SHALL hold the FSM state encoding, default DATA_WIDTH/M/N/P constants and a clog2-based counter-width function.
REQ-031 One sub-module matrix_pack_reg (indexed element write into a packed register, async reset) SHALL be instantiated once for A and once for B.

Verification
REQ-032 M=N=P=2, stream A=1,2,3,4 then B=5,6,7,8 back-to-back -> matrix_a=0x04030201, matrix_b=0x08070605, mm_start high one cycle, the cycle after B[3] transfer.
REQ-033 Same frame with s_valid low every other cycle -> identical packed outputs, single mm_start; s_ready 0 throughout WAIT_DONE.
REQ-034 mm_done held high before second frame's start, then low, then high 5 cycles later -> WAIT_DONE exits only on that later rising edge; s_ready returns 1 the next cycle.
REQ-035 rst asserted after 3 A elements -> all outputs zero immediately; fresh full frame then loads correctly, exactly one mm_start.
REQ-036 LOADER_LAST_CHECK_EN defined, s_last high on A[2] -> err_frame=1, no mm_start, loader back in LOAD_A; next correctly framed transfer set (s_last on B[3]) produces mm_start with err_frame still 1.
REQ-037 Negative values -8 and 127 at DATA_WIDTH=8 -> stored as 0xF8 and 0x7F in the correct slots.
